// File: rtl/bus_slave_if.sv
// -----------------------------------------------------------------------------
// bus_slave_if
// Shared CPU bus bundle between a bus master (the mips core or a bench) and a
// memory-style responder.
//
// Signals:
//   bus_ctrl_in   master -> slave  command code (NOP/READ/WRITE/DATA/ABORT...)
//   bus_data_in   master -> slave  address on command cycles, write data on DATA
//   bus_ctrl_out  slave  -> master response code (NOP/DATA/DONE)
//   bus_data_out  slave  -> master read data, zero when not driving
//   bus_data_oe   slave  -> master high only while read data is driven
//   busy          slave  -> master slave is inside a transaction
// -----------------------------------------------------------------------------
interface bus_slave_if #(
    parameter int DWIDTH = 32,
    parameter int CWIDTH = 3
);
    logic [CWIDTH-1:0] bus_ctrl_in;
    logic [DWIDTH-1:0] bus_data_in;
    logic [CWIDTH-1:0] bus_ctrl_out;
    logic [DWIDTH-1:0] bus_data_out;
    logic              bus_data_oe;
    logic              busy;

    modport master (
        output bus_ctrl_in,
        output bus_data_in,
        input  bus_ctrl_out,
        input  bus_data_out,
        input  bus_data_oe,
        input  busy
    );

    modport slave (
        input  bus_ctrl_in,
        input  bus_data_in,
        output bus_ctrl_out,
        output bus_data_out,
        output bus_data_oe,
        output busy
    );
endinterface

// File: rtl/bus_slave_mem.sv
// -----------------------------------------------------------------------------
// bus_slave_mem
// Word-addressed memory responder on the shared CPU bus. Decodes a READ/WRITE
// command, checks the address window, returns read data after WAIT_STATES
// wait cycles or accepts one write data word, then signals DONE.
//
// Ports:
//   clk       rising-edge system clock
//   reset     asynchronous active-high reset (memory contents are kept)
//   bus       bus_slave_if.slave (command in, response/read data/busy out)
//   debug_ra  debug read word index
//   debug_rd  combinational mem[debug_ra]
//
// Optional feature: define BUS_SLAVE_BURST_EN to add RBURST (3'b100) and
// WBURST (3'b101) 4-word wrapping bursts. Without it those codes are ignored.
//
// Timing: all bus outputs are registered from the current FSM state, so every
// response appears one cycle after the state that produces it. A READ sampled
// at edge N shows DATA after edge N+1+WAIT_STATES. busy follows the same lag,
// and IDLE only accepts a command once busy has dropped, i.e. the cycle after
// DONE is visible.
// -----------------------------------------------------------------------------
module bus_slave_mem #(
    parameter int                 DWIDTH      = 32,
    parameter int                 CWIDTH      = 3,
    parameter int                 AWIDTH      = 8,
    parameter logic [DWIDTH-1:0]  BASE_ADDR   = 32'h0000_1000,
    parameter logic [DWIDTH-1:0]  ADDR_MASK   = 32'hFFFF_FC00,
    parameter int                 WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    bus_slave_if.slave        bus,
    input  logic [AWIDTH-1:0] debug_ra,
    output logic [DWIDTH-1:0] debug_rd
);

    localparam int DEPTH = 1 << AWIDTH;

    localparam logic [CWIDTH-1:0] M_READ   = CWIDTH'(3'b001);
    localparam logic [CWIDTH-1:0] M_WRITE  = CWIDTH'(3'b010);
    localparam logic [CWIDTH-1:0] M_DATA   = CWIDTH'(3'b011);
    localparam logic [CWIDTH-1:0] M_ABORT  = CWIDTH'(3'b111);
`ifdef BUS_SLAVE_BURST_EN
    localparam logic [CWIDTH-1:0] M_RBURST = CWIDTH'(3'b100);
    localparam logic [CWIDTH-1:0] M_WBURST = CWIDTH'(3'b101);
`endif
    localparam logic [CWIDTH-1:0] R_NOP    = CWIDTH'(3'b000);
    localparam logic [CWIDTH-1:0] R_DATA   = CWIDTH'(3'b011);
    localparam logic [CWIDTH-1:0] R_DONE   = CWIDTH'(3'b110);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_WAIT = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_DATA = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [3:0]          cnt_r;
    logic [3:0]          cnt_next_s;
    logic [AWIDTH-1:0]   idx_r;
    logic [AWIDTH-1:0]   cur_idx_s;
    logic                last_beat_s;
    logic                wr_en_s;
    logic                is_rd_s;
    logic                is_wr_s;
    logic                hit_s;
    logic                abort_s;
    logic                start_rd_s;
    logic                start_wr_s;
    logic [CWIDTH-1:0]   ctrl_out_r;
    logic [DWIDTH-1:0]   data_out_r;
    logic                data_oe_r;
    logic                busy_r;
    logic [DWIDTH-1:0]   mem_r [0:DEPTH-1];
`ifdef BUS_SLAVE_BURST_EN
    logic                is_burst_s;
    logic                burst_r;
    logic [1:0]          beat_r;
`endif

    assign hit_s      = ((bus.bus_data_in & ADDR_MASK) == BASE_ADDR);
    assign abort_s    = (bus.bus_ctrl_in == M_ABORT);
    // Commands are only taken once the previous transaction has fully retired.
    assign start_rd_s = (state_r == S_IDLE) && !busy_r && hit_s && is_rd_s;
    assign start_wr_s = (state_r == S_IDLE) && !busy_r && hit_s && is_wr_s;

`ifdef BUS_SLAVE_BURST_EN
    // Bursts wrap inside the aligned 4-word block, critical word first.
    assign cur_idx_s   = {idx_r[AWIDTH-1:2], idx_r[1:0] + beat_r};
    assign last_beat_s = !burst_r || (beat_r == 2'd3);
`else
    assign cur_idx_s   = idx_r;
    assign last_beat_s = 1'b1;
`endif

    // Classify the master command code.
    always_comb begin
        is_rd_s = 1'b0;
        is_wr_s = 1'b0;
`ifdef BUS_SLAVE_BURST_EN
        is_burst_s = 1'b0;
`endif
        case (bus.bus_ctrl_in)
            M_READ:   is_rd_s = 1'b1;
            M_WRITE:  is_wr_s = 1'b1;
`ifdef BUS_SLAVE_BURST_EN
            M_RBURST: begin
                is_rd_s    = 1'b1;
                is_burst_s = 1'b1;
            end
            M_WBURST: begin
                is_wr_s    = 1'b1;
                is_burst_s = 1'b1;
            end
`endif
            default:  is_rd_s = 1'b0;
        endcase
    end

    // Next-state, wait counter and write-enable decode.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        wr_en_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start_rd_s) begin
                    if (WAIT_STATES == 0) begin
                        state_next_s = S_RD_DATA;
                        cnt_next_s   = 4'd0;
                    end else begin
                        state_next_s = S_RD_WAIT;
                        cnt_next_s   = WAIT_LOAD;
                    end
                end else if (start_wr_s) begin
                    state_next_s = S_WR_DATA;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_RD_WAIT: begin
                if (abort_s) begin
                    state_next_s = S_IDLE;
                    cnt_next_s   = 4'd0;
                end else begin
                    // Leaving on the final count keeps RD_WAIT exactly WAIT_STATES cycles long.
                    cnt_next_s   = (cnt_r == 4'd0) ? 4'd0 : cnt_r - 4'd1;
                    state_next_s = (cnt_r <= 4'd1) ? S_RD_DATA : S_RD_WAIT;
                end
            end
            S_RD_DATA: begin
                if (abort_s) begin
                    state_next_s = S_IDLE;
                end else if (last_beat_s) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_RD_DATA;
                end
            end
            S_WR_DATA: begin
                if (abort_s) begin
                    state_next_s = S_IDLE;
                end else if (bus.bus_ctrl_in == M_DATA) begin
                    wr_en_s      = 1'b1;
                    state_next_s = last_beat_s ? S_DONE : S_WR_DATA;
                end else begin
                    state_next_s = S_WR_DATA;
                end
            end
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // FSM state, wait counter, latched index and burst beat tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
            cnt_r   <= 4'd0;
            idx_r   <= '0;
`ifdef BUS_SLAVE_BURST_EN
            burst_r <= 1'b0;
            beat_r  <= 2'd0;
`endif
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            if (start_rd_s || start_wr_s) begin
                idx_r <= bus.bus_data_in[AWIDTH+1:2];
            end
`ifdef BUS_SLAVE_BURST_EN
            if (start_rd_s || start_wr_s) begin
                burst_r <= is_burst_s;
                beat_r  <= 2'd0;
            end else if (((state_r == S_RD_DATA) && !abort_s) || wr_en_s) begin
                beat_r  <= beat_r + 2'd1;
            end
`endif
        end
    end

    // Registered bus response, one cycle behind the FSM state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_out_r <= R_NOP;
            data_out_r <= '0;
            data_oe_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            busy_r <= (state_r != S_IDLE);
            case (state_r)
                S_RD_DATA: begin
                    ctrl_out_r <= R_DATA;
                    data_out_r <= mem_r[cur_idx_s];
                    data_oe_r  <= 1'b1;
                end
                S_DONE: begin
                    ctrl_out_r <= R_DONE;
                    data_out_r <= '0;
                    data_oe_r  <= 1'b0;
                end
                default: begin
                    ctrl_out_r <= R_NOP;
                    data_out_r <= '0;
                    data_oe_r  <= 1'b0;
                end
            endcase
        end
    end

    // Memory array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[cur_idx_s] <= bus.bus_data_in;
        end
    end

    assign debug_rd         = mem_r[debug_ra];
    assign bus.bus_ctrl_out = ctrl_out_r;
    assign bus.bus_data_out = data_out_r;
    assign bus.bus_data_oe  = data_oe_r;
    assign bus.busy         = busy_r;

endmodule
